spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_pkg.sv | 28 ++
 rtl/crc8_serial.sv | 30 +++
 rtl/spi_master_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the SPI master controller and its CRC helper.
package spi_master_ctrl_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned DATA_BITS  = 24;
  localparam int unsigned CRC_BITS   = 8;

  localparam logic [CRC_BITS-1:0] CRC_INIT         = 8'hFF;
  localparam logic [CRC_BITS-1:0] CRC_POLY_DEFAULT = 8'h1D;

  typedef enum logic [2:0] {
    StIdle,
    StCrc,
    StShift,
    StHold,
    StGap
  } state_e;

  // One MSB-first CRC step: no reflection, feedback from crc msb xor incoming bit.
  function automatic logic [CRC_BITS-1:0] crc8_step(input logic [CRC_BITS-1:0] crc,
                                                    input logic                din,
                                                    input logic [CRC_BITS-1:0] poly);
    logic [CRC_BITS-1:0] shifted;
    shifted = {crc[CRC_BITS-2:0], 1'b0};
    return (crc[CRC_BITS-1] ^ din) ? (shifted ^ poly) : shifted;
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator; clear has priority over enable.
module crc8_serial
  import spi_master_ctrl_pkg::*;
#(
  parameter logic [CRC_BITS-1:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                clr,
  input  logic                din,
  output logic [CRC_BITS-1:0] crc
);

  logic [CRC_BITS-1:0] crc_q;

  // CRC register: reload seed on clear, fold one bit per enabled cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= CRC_INIT;
    end else if (clr) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, din, POLY);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: 24-bit payload + CRC-8 frame, mode-0 style timing, full-duplex receive
// with CRC verification of the returned payload.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned         CLK_DIV  = 4,
  parameter logic [CRC_BITS-1:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 abort,
  output logic                 ready,
  output logic                 done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [CRC_BITS-1:0]  rx_crc,
  output logic                 crc_ok,
  output logic                 sck,
  output logic                 csn,
  output logic                 mosi,
  input  logic                 miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e state_q, state_d;

  logic [7:0]            div_q, div_d;
  logic [5:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;

  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  sck_q, sck_d;
  logic                  csn_q, csn_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic [CRC_BITS-1:0]   rx_crc_q, rx_crc_d;
  logic                  crc_ok_q, crc_ok_d;

  logic                  tx_crc_en, tx_crc_clr;
  logic                  rx_crc_en, rx_crc_clr;
  logic [CRC_BITS-1:0]   tx_crc, rx_crc_calc;
  logic [FRAME_BITS-1:0] frame;
  logic [4:0]            frame_idx;
  logic                  half_end;
  logic                  busy;

  // The CRC field is only read from pulse 24 onward, long after the CRC phase settled it.
  assign frame     = {tx_q, tx_crc};
  assign frame_idx = 5'(31 - int'(bit_q));
  assign half_end  = (div_q == DIV_LAST);
  assign busy      = (state_q == StCrc) || (state_q == StShift) || (state_q == StHold);

  crc8_serial #(
    .POLY (CRC_POLY)
  ) u_tx_crc (
    .clk  (clk),
    .rstn (rstn),
    .en   (tx_crc_en),
    .clr  (tx_crc_clr),
    .din  (frame[frame_idx]),
    .crc  (tx_crc)
  );

  crc8_serial #(
    .POLY (CRC_POLY)
  ) u_rx_crc (
    .clk  (clk),
    .rstn (rstn),
    .en   (rx_crc_en),
    .clr  (rx_crc_clr),
    .din  (miso),
    .crc  (rx_crc_calc)
  );

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_sr_d    = rx_sr_q;
    done_d     = 1'b0;
    sck_d      = sck_q;
    csn_d      = csn_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_crc_d   = rx_crc_q;
    crc_ok_d   = crc_ok_q;
    tx_crc_en  = 1'b0;
    tx_crc_clr = 1'b0;
    rx_crc_en  = 1'b0;
    rx_crc_clr = 1'b0;

    if (abort && busy) begin
      // Drop the frame immediately; still honour the minimum deselect time.
      state_d = StGap;
      div_d   = '0;
      bit_d   = '0;
      sck_d   = 1'b0;
      csn_d   = 1'b1;
      mosi_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StCrc;
            tx_d       = tx_data;
            bit_d      = '0;
            div_d      = '0;
            tx_crc_clr = 1'b1;
            rx_crc_clr = 1'b1;
          end
        end
        StCrc: begin
          // frame[31:8] is tx_q, so the same index walks the payload MSB first.
          tx_crc_en = 1'b1;
          if (bit_q == 6'd23) begin
            state_d = StShift;
            bit_d   = '0;
            div_d   = '0;
            csn_d   = 1'b0;
            sck_d   = 1'b0;
            mosi_d  = tx_q[DATA_BITS-1];
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
        StShift: begin
          if (half_end) begin
            div_d = '0;
            if (!sck_q) begin
              sck_d = 1'b1;
              // Bit 31 was already presented with csn; later bits move on each rise.
              if (bit_q != 6'd0) begin
                mosi_d = frame[frame_idx];
              end
            end else begin
              sck_d   = 1'b0;
              rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], miso};
              if (bit_q < 6'd24) begin
                rx_crc_en = 1'b1;
              end
              if (bit_q == 6'd31) begin
                state_d = StHold;
                bit_d   = '0;
              end else begin
                bit_d = bit_q + 6'd1;
              end
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        StHold: begin
          if (half_end) begin
            state_d   = StGap;
            div_d     = '0;
            csn_d     = 1'b1;
            mosi_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_sr_q[FRAME_BITS-1:CRC_BITS];
            rx_crc_d  = rx_sr_q[CRC_BITS-1:0];
            crc_ok_d  = (rx_crc_calc == rx_sr_q[CRC_BITS-1:0]);
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        StGap: begin
          if (half_end) begin
            state_d = StIdle;
            div_d   = '0;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    ready_d = (state_d == StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sr_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      csn_q     <= 1'b1;
      mosi_q    <= 1'b0;
      rx_data_q <= '0;
      rx_crc_q  <= '0;
      crc_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      csn_q     <= csn_d;
      mosi_q    <= mosi_d;
      rx_data_q <= rx_data_d;
      rx_crc_q  <= rx_crc_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign csn     = csn_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_data_q;
  assign rx_crc  = rx_crc_q;
  assign crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: loopback, bit-flip, slave model, abort,
// mid-frame reset, and back-to-back frames on a second instance with CLK_DIV=2.
module tb_spi_master_ctrl;

  localparam int unsigned CD  = 4;
  localparam int unsigned CD2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start, abort, ready, done, crc_ok, sck, csn, mosi, miso;
  logic [23:0] tx_data, rx_data;
  logic [7:0]  rx_crc;

  logic        start2, abort2, ready2, done2, crc_ok2, sck2, csn2, mosi2, miso2;
  logic [23:0] tx_data2, rx_data2;
  logic [7:0]  rx_crc2;

  spi_master_ctrl #(.CLK_DIV(CD), .CRC_POLY(8'h1D)) dut (
    .clk(clk), .rstn(rstn), .start(start), .tx_data(tx_data), .abort(abort),
    .ready(ready), .done(done), .rx_data(rx_data), .rx_crc(rx_crc), .crc_ok(crc_ok),
    .sck(sck), .csn(csn), .mosi(mosi), .miso(miso)
  );

  spi_master_ctrl #(.CLK_DIV(CD2), .CRC_POLY(8'h1D)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .tx_data(tx_data2), .abort(abort2),
    .ready(ready2), .done(done2), .rx_data(rx_data2), .rx_crc(rx_crc2), .crc_ok(crc_ok2),
    .sck(sck2), .csn(csn2), .mosi(mosi2), .miso(miso2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC-8: init FF, poly 1D, MSB first, no final xor.
  function automatic logic [7:0] crc8(input logic [23:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 23; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h1D;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Slave side: loopback (optionally corrupting pulse 5) or shifting out slave_word.
  logic        loopback = 1'b1;
  logic        flip_en  = 1'b0;
  int          pulse_idx = -1;
  logic [31:0] slave_word = '0;
  logic [31:0] slave_sr   = '0;
  logic [31:0] slave_cap  = '0;

  assign miso  = loopback ? (mosi ^ (flip_en && pulse_idx == 5)) : slave_sr[31];
  assign miso2 = mosi2;

  initial forever begin
    @(negedge csn);
    pulse_idx = -1;
    slave_sr  = slave_word;
  end

  initial forever begin
    @(posedge sck);
    pulse_idx = pulse_idx + 1;
  end

  initial forever begin
    @(negedge sck);
    slave_cap = {slave_cap[30:0], mosi};
    slave_sr  = {slave_sr[30:0], 1'b0};
  end

  // Scoreboard and monitor for the main instance.
  typedef struct {
    logic [23:0] data;
    logic [7:0]  crc;
    logic        ok;
  } exp_t;

  exp_t exp_q[$];
  int   done_cnt = 0;
  int   csn_low  = 0;
  int   pulses   = 0;
  logic sck_prev = 1'b0;
  logic csn_prev = 1'b1;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (csn_prev === 1'b1 && csn === 1'b0) begin
      csn_low = 1;
      pulses  = 0;
    end else if (csn === 1'b0) begin
      csn_low++;
    end
    if (sck === 1'b1 && sck_prev === 1'b0) pulses++;
    sck_prev = sck;
    csn_prev = csn;
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("rx_crc", 32'(rx_crc), 32'(e.crc));
        chk("crc_ok", 32'(crc_ok), 32'(e.ok));
        chk("sck_pulses", pulses, 32);
        chk("csn_low_cycles", csn_low, 65 * CD);
      end
    end
  end

  task automatic send_frame(input logic [23:0] d, input bit push,
                            input logic [23:0] ed, input logic [7:0] ec, input logic eo);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", 32'(ready), 1);
    tx_data = d;
    start   = 1'b1;
    if (push) begin
      e.data = ed;
      e.crc  = ec;
      e.ok   = eo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int c;
    c = 0;
    while (done_cnt < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("done_count", done_cnt, n);
  endtask

  task automatic wait_pulse(input int k);
    int c;
    c = 0;
    while (pulse_idx != k && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("reach_pulse", pulse_idx, k);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_csn"}, 32'(csn), 1);
    chk({tag, "_sck"}, 32'(sck), 0);
    chk({tag, "_mosi"}, 32'(mosi), 0);
    chk({tag, "_rx_data"}, 32'(rx_data), 0);
    chk({tag, "_rx_crc"}, 32'(rx_crc), 0);
    chk({tag, "_crc_ok"}, 32'(crc_ok), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi, lo, rdy, frames2;
    logic prev2;
    bit   seen;

    rstn = 1'b0; start = 1'b0; abort = 1'b0; tx_data = '0;
    start2 = 1'b0; abort2 = 1'b0; tx_data2 = 24'h0F1E2D;
    repeat (3) @(negedge clk);
    chk_reset("reset");

    // Start is already high when reset releases: accepted on the very first edge.
    tx_data = 24'hFEDCBA;
    start   = 1'b1;
    exp_q.push_back('{data: 24'hFEDCBA, crc: crc8(24'hFEDCBA), ok: 1'b1});
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("first_start_accepted", 32'(ready), 0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1);

    // Corrupt the sample of pulse 5: received bit 26 -> rx_data bit 18.
    flip_en = 1'b1;
    send_frame(24'hFEDCBA, 1'b1, 24'hFEDCBA ^ 24'h040000, crc8(24'hFEDCBA), 1'b0);
    wait_done(2);
    flip_en = 1'b0;

    // Slave returns A5A5A5 with its hand-computed CRC 62.
    loopback   = 1'b0;
    slave_word = {24'hA5A5A5, 8'h62};
    send_frame(24'h123456, 1'b1, 24'hA5A5A5, 8'h62, 1'b1);
    wait_done(3);
    chk("slave_capture", slave_cap, {24'h123456, crc8(24'h123456)});
    loopback = 1'b1;

    // Abort during pulse 10.
    send_frame(24'h55AA33, 1'b0, '0, '0, 1'b0);
    wait_pulse(10);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_csn", 32'(csn), 1);
    chk("abort_sck", 32'(sck), 0);
    chk("abort_ready_now", 32'(ready), 0);
    abort = 1'b0;
    repeat (CD - 1) @(posedge clk);
    #1 chk("abort_ready_early", 32'(ready), 0);
    @(posedge clk);
    #1 chk("abort_ready", 32'(ready), 1);
    chk("abort_no_done", done_cnt, 3);
    chk("abort_rx_data_kept", 32'(rx_data), 32'h00A5A5A5);
    chk("abort_rx_crc_kept", 32'(rx_crc), 32'h62);
    chk("abort_crc_ok_kept", 32'(crc_ok), 1);

    // Asynchronous reset in the middle of the shift phase, then a clean restart.
    send_frame(24'h3C3C3C, 1'b0, '0, '0, 1'b0);
    wait_pulse(3);
    #2 rstn = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    rstn = 1'b1;
    send_frame(24'h3C3C3C, 1'b1, 24'h3C3C3C, crc8(24'h3C3C3C), 1'b1);
    wait_done(4);

    // Back-to-back on the CLK_DIV=2 instance with start held high.
    hi = 0; lo = 0; rdy = 0; frames2 = 0; prev2 = 1'b1; seen = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    for (int cyc = 0; cyc < 1500 && frames2 < 3; cyc++) begin
      @(negedge clk);
      if (csn2 === 1'b0 && prev2 === 1'b1) begin
        // Deselect spans GAP, one IDLE cycle and the 24-cycle CRC phase.
        if (seen) begin
          chk("b2b_csn_high", hi, CD2 + 1 + 24);
          chk("b2b_ready_cycles", rdy, 1);
        end
        lo = 0;
      end
      if (csn2 === 1'b1 && prev2 === 1'b0) begin
        chk("b2b_csn_low", lo, 65 * CD2);
        hi = 0;
        rdy = 0;
        seen = 1'b1;
      end
      if (csn2 === 1'b1) begin
        hi++;
        if (ready2 === 1'b1) rdy++;
      end else begin
        lo++;
      end
      if (done2 === 1'b1) begin
        frames2++;
        chk("b2b_rx_data", 32'(rx_data2), 32'h000F1E2D);
        chk("b2b_crc_ok", 32'(crc_ok2), 1);
      end
      prev2 = csn2;
    end
    start2 = 1'b0;
    chk("b2b_frames", frames2, 3);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_done_count", done_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
